mem_port_arbiter: RTL and testbench

- Shares one unified single-port byte-addressable memory between two requesters: instruction fetch (IF) and load/store data (D).
- Used in the multi-cycle variant of the RV32 core, where one memory replaces the separate instruction and data memories.
- Accepts requests over req/gnt, sequences a fixed-latency memory access, and returns read data with a one-cycle valid pulse.
- Fetch starvation is prevented by a bounded-wait counter.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of D-priority with a fetch starvation bound.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int AWIDTH     = 10,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WIDTH-1:0]  if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WIDTH-1:0]  if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_byte,
  input  logic [WIDTH-1:0]  d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              mem_wr,
  output logic [1:0]        mem_byte,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              own_d;
  logic              lat_wr;
  logic [1:0]        lat_byte;
  logic [AWIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic              d_win;
  logic              unused;

  assign unused = ^{if_addr[WIDTH-1:AWIDTH], d_addr[WIDTH-1:AWIDTH]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 = D was granted most recently

  assign d_win = d_req && !(if_req && last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_d <= 1'b0;
    else if (d_gnt)  last_d <= 1'b1;
    else if (if_gnt) last_d <= 1'b0;
  end
`else
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;

  assign d_win = d_req && !(if_req && starve == SW'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve <= '0;
    else if (d_gnt && if_req)
      starve <= (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
    else if (if_gnt)
      starve <= '0;
  end
`endif

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (d_win)       d_gnt  = 1'b1;
          else if (if_req) if_gnt = 1'b1;
        end
        if (d_gnt || if_gnt) state_nxt = WAIT;
      end
      WAIT: if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched request drives the memory; it simply holds once the access is done.
  assign busy      = (state == WAIT);
  assign mem_wr    = busy && lat_wr && (cnt == CW'(LAT));
  assign mem_addr  = lat_addr;
  assign mem_byte  = lat_byte;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      own_d     <= 1'b0;
      lat_wr    <= 1'b0;
      lat_byte  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (d_gnt || if_gnt) begin
        own_d    <= d_gnt;
        lat_wr   <= d_gnt && d_wr;
        lat_byte <= d_gnt ? d_byte : 2'b10;  // fetches are always full words
        lat_addr <= d_gnt ? d_addr[AWIDTH-1:0] : if_addr[AWIDTH-1:0];
        if (d_gnt) lat_wdata <= d_wdata;
        cnt      <= CW'(LAT);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (own_d) begin
            d_rvalid <= 1'b1;
            if (!lat_wr) d_rdata <= mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word memory model plus an in-order grant/response scoreboard.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_byte = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wr, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [1:0]  mem_byte;
  logic [9:0]  mem_addr;

  logic [31:0] mem [0:255];

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_ld = '0;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  mem_port_arbiter #(.WIDTH(32), .AWIDTH(10), .LAT(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_wr(mem_wr), .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

  // Scoreboard: push on grant, pop on rvalid, require order, data and T+LAT+1 timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      last_ld = '0;
    end else begin
      cyc++;
      if (if_rvalid || d_rvalid) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected: if_rvalid=%0b d_rvalid=%0b with no pending access at cyc %0d", if_rvalid, d_rvalid, cyc);
        end else begin
          e = sb.pop_front();
          if ((if_rvalid && d_rvalid) || (d_rvalid !== e.is_d) ||
              ((e.is_d ? d_rdata : if_rdata) !== e.data) || (cyc != e.cyc + LAT + 1)) begin
            mismatched++;
            $display("FAIL sb_resp: got d=%0b if=%0b data=%h cyc=%0d, want d=%0b data=%h cyc=%0d",
                     d_rvalid, if_rvalid, e.is_d ? d_rdata : if_rdata, cyc, e.is_d, e.data, e.cyc + LAT + 1);
          end
        end
      end
      if (if_gnt || d_gnt) begin
        compared++;
        if (if_gnt && d_gnt) begin
          mismatched++;
          $display("FAIL both_gnt: if_gnt=1 d_gnt=1, want at most one");
        end
        e.is_d = d_gnt;
        e.cyc  = cyc;
        if (d_gnt) begin
          e.data = d_wr ? last_ld : mem[d_addr[9:2]];
          if (!d_wr) last_ld = e.data;
        end else begin
          e.data = mem[if_addr[9:2]];
        end
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    compared++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr, busy, mem_byte, mem_addr} !== '0 ||
        mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: gnt=%b%b rv=%b%b wr=%b busy=%b addr=%h rd=%h/%h, want all 0",
               if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr, busy, mem_addr, if_rdata, d_rdata);
    end
    tick();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    int  n = 0;
    int  last = 0;
    logic exp_d;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h44;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (n % 2 == 0);
`else
        exp_d = (n % 5 != 4);
`endif
        compared++;
        if (d_gnt !== exp_d) begin
          mismatched++;
          $display("FAIL arb_order: grant %0d d_gnt=%b if_gnt=%b, want d_gnt=%b", n, d_gnt, if_gnt, exp_d);
        end
        if (n > 0) begin
          compared++;
          if (i - last != LAT + 1) begin
            mismatched++;
            $display("FAIL arb_spacing: grant %0d spacing %0d, want %0d", n, i - last, LAT + 1);
          end
        end
        last = i;
        n++;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    compared++;
    if (n != 10) begin
      mismatched++;
      $display("FAIL arb_count: %0d grants in 30 cycles, want 10", n);
    end
    repeat (5) tick();
  endtask

  // Single D access; checks gnt at T, mem bus at T+1..T+LAT, rvalid pulse at T+LAT+1.
  task automatic d_access(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] bsz,
                          input logic [9:0] exp_ma, input logic [31:0] exp_rd);
    d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata; d_byte = bsz;
    @(negedge clk);
    compared++;
    if (d_gnt !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_gnt: d_gnt=%b, want 1", nm, d_gnt);
    end
    tick();
    d_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      compared++;
      if (mem_addr !== exp_ma || busy !== 1'b1 || mem_wr !== (wr && k == 1) ||
          (wr && (mem_byte !== bsz || mem_wdata !== wdata))) begin
        mismatched++;
        $display("FAIL %s_bus T+%0d: addr=%h busy=%b wr=%b byte=%h wdata=%h, want addr=%h busy=1 wr=%b",
                 nm, k, mem_addr, busy, mem_wr, mem_byte, mem_wdata, exp_ma, wr && k == 1);
      end
    end
    @(negedge clk);
    compared++;
    if (d_rvalid !== 1'b1 || d_rdata !== exp_rd || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_resp: d_rvalid=%b d_rdata=%h busy=%b, want 1 %h 0", nm, d_rvalid, d_rdata, busy, exp_rd);
    end
    @(negedge clk);
    compared++;
    if (d_rvalid !== 1'b0 || mem_wr !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_pulse: d_rvalid=%b mem_wr=%b after response, want 0 0", nm, d_rvalid, mem_wr);
    end
    tick();
  endtask

  task automatic test_load();
    d_access("load", 1'b0, 32'h10, 32'h0, 2'd0, 10'h010, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    d_access("store", 1'b1, 32'h3FC, 32'h12345678, 2'd2, 10'h3FC, 32'hDEADBEEF);
    compared++;
    if (mem[255] !== 32'h12345678) begin
      mismatched++;
      $display("FAIL store_mem: mem[0x3FC]=%h, want 12345678", mem[255]);
    end
  endtask

  task automatic test_addr_trunc();
    d_access("trunc", 1'b0, 32'hFFFF_F404, 32'h0, 2'd0, 10'h004, 32'hA000_0001);
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    compared++;
    if (if_gnt !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_gnt: if_gnt=%b, want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    rst = 1'b1;
    #1;
    compared++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr, busy, mem_byte, mem_addr} !== '0 ||
        mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
      mismatched++;
      $display("FAIL rmid_outputs: busy=%b addr=%h byte=%h rd=%h/%h, want all 0", busy, mem_addr, mem_byte, if_rdata, d_rdata);
    end
    tick();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h24;
    @(negedge clk);
    compared++;
    if (if_gnt !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_regnt: if_gnt=%b first cycle after reset, want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      compared++;
      if (if_rvalid !== (k == LAT + 1) || (k == LAT + 1 && if_rdata !== 32'hA000_0009)) begin
        mismatched++;
        $display("FAIL rmid_resp T+%0d: if_rvalid=%b if_rdata=%h, want %b A0000009", k, if_rvalid, if_rdata, k == LAT + 1);
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[4] = 32'hDEADBEEF;
    #2;
    test_reset();
    test_arbitration();
    test_load();
    test_store();
    test_addr_trunc();
    test_reset_mid();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: %0d responses never arrived, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
